// File: rtl/shot_clock_param.sv
// Shot-clock counter: two-digit BCD countdown with prescaler, full/short reload,
// timed expiry alarm and 7-segment decode with optional leading-zero blanking.
module shot_clock_param #(
  parameter int unsigned CLK_DIV        = 50_000_000,
  parameter int unsigned PRESET_FULL    = 24,
  parameter int unsigned PRESET_SHORT   = 14,
  parameter int unsigned ALARM_CYCLES   = 100_000_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       reload_full,
  input  logic       reload_short,
  output logic [3:0] timesh,
  output logic [3:0] timesl,
  output logic       alarm,
  output logic       expired,
  output logic [6:0] display1,
  output logic [6:0] display2
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  localparam logic [PW-1:0] PreMax = PW'(CLK_DIV - 1);
  localparam logic [AW-1:0] AlmMax = AW'((ALARM_CYCLES > 0) ? ALARM_CYCLES - 1 : 0);

  localparam logic [3:0] FullTens   = 4'(PRESET_FULL / 10);
  localparam logic [3:0] FullUnits  = 4'(PRESET_FULL % 10);
  localparam logic [3:0] ShortTens  = 4'(PRESET_SHORT / 10);
  localparam logic [3:0] ShortUnits = 4'(PRESET_SHORT % 10);

  typedef enum logic [0:0] {StCount, StExpired} state_e;

  state_e        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          alarm_q, alarm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StCount;
      tens_q  <= FullTens;
      units_q <= FullUnits;
      presc_q <= '0;
      acnt_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    presc_d = presc_q;
    acnt_d  = acnt_q;
    alarm_d = alarm_q;

    if (reload_full || reload_short) begin
      // Full preset wins when both reloads are asserted together.
      tens_d  = reload_full ? FullTens : ShortTens;
      units_d = reload_full ? FullUnits : ShortUnits;
      presc_d = '0;
      acnt_d  = '0;
      alarm_d = 1'b0;
      state_d = StCount;
    end else begin
      case (state_q)
        StCount: begin
          if (!pause) begin
            if (presc_q == PreMax) begin
              presc_d = '0;
              if (units_q == 4'd0) begin
                units_d = 4'd9;
                tens_d  = tens_q - 4'd1;
              end else begin
                units_d = units_q - 4'd1;
              end
              if (tens_q == 4'd0 && units_q == 4'd1) begin
                state_d = StExpired;
                alarm_d = 1'b1;
                acnt_d  = '0;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        StExpired: begin
          // A zero duration keeps the alarm latched until the next reload.
          if (alarm_q && ALARM_CYCLES != 0) begin
            if (acnt_q == AlmMax) begin
              alarm_d = 1'b0;
            end else begin
              acnt_d = acnt_q + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [6:0] seg_tens, seg_units;

  always_comb begin
    seg_tens  = (BLANK_LZ && tens_q == 4'd0) ? 7'b0000000 : seg7(tens_q);
    seg_units = seg7(units_q);
  end

  assign display1 = SEG_ACTIVE_LOW ? ~seg_tens : seg_tens;
  assign display2 = SEG_ACTIVE_LOW ? ~seg_units : seg_units;
  assign timesh   = tens_q;
  assign timesl   = units_q;
  assign alarm    = alarm_q;
  assign expired  = (state_q == StExpired);

endmodule

// File: tb/tb_shot_clock_param.sv
// Bench for shot_clock_param: decimal-count reference model checked every cycle on two
// instances (with and without leading-zero blanking), plus directed literal checks.
module tb_shot_clock_param;

  localparam int Div   = 4;
  localparam int Alm   = 3;
  localparam int Full  = 24;
  localparam int Short = 14;

  // Active-high segment patterns for 0..9, {g,f,e,d,c,b,a}.
  localparam logic [6:0] Seg [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                      7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic reload_full = 1'b0;
  logic reload_short = 1'b0;

  logic [3:0] th0, tl0, th1, tl1;
  logic       al0, ex0, al1, ex1;
  logic [6:0] d10, d20, d11, d21;

  always #5 clk = ~clk;

  shot_clock_param #(
    .CLK_DIV(Div), .PRESET_FULL(Full), .PRESET_SHORT(Short), .ALARM_CYCLES(Alm),
    .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .pause(pause), .reload_full(reload_full),
    .reload_short(reload_short), .timesh(th0), .timesl(tl0), .alarm(al0),
    .expired(ex0), .display1(d10), .display2(d20)
  );

  shot_clock_param #(
    .CLK_DIV(Div), .PRESET_FULL(Full), .PRESET_SHORT(Short), .ALARM_CYCLES(Alm),
    .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .pause(pause), .reload_full(reload_full),
    .reload_short(reload_short), .timesh(th1), .timesl(tl1), .alarm(al1),
    .expired(ex1), .display1(d11), .display2(d21)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_disp(input int digit, input bit blank);
    logic [6:0] s;
    s = blank ? 7'h00 : Seg[digit];
    return ~s;
  endfunction

  // Reference model: count in plain decimal seconds.
  int m_cnt = 0;
  int m_pre = 0;
  int m_left = 0;
  bit m_alarm = 1'b0;
  bit m_exp = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = Full; m_pre = 0; m_alarm = 0; m_exp = 0; m_left = 0; m_valid = 1;
    end else if (!m_valid) begin
      m_cnt = m_cnt;
    end else if (reload_full || reload_short) begin
      m_cnt = reload_full ? Full : Short;
      m_pre = 0; m_alarm = 0; m_exp = 0; m_left = 0;
    end else if (m_exp) begin
      if (m_alarm) begin
        m_left = m_left - 1;
        if (m_left == 0) m_alarm = 0;
      end
    end else if (!pause) begin
      if (m_pre == Div - 1) begin
        m_pre = 0;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_exp = 1; m_alarm = 1; m_left = Alm;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("timesh0", th0, m_cnt / 10);
      check("timesl0", tl0, m_cnt % 10);
      check("alarm0", al0, m_alarm);
      check("expired0", ex0, m_exp);
      check("display1_0", d10, exp_disp(m_cnt / 10, 1'b0));
      check("display2_0", d20, exp_disp(m_cnt % 10, 1'b0));
      check("timesh1", th1, m_cnt / 10);
      check("timesl1", tl1, m_cnt % 10);
      check("alarm1", al1, m_alarm);
      check("expired1", ex1, m_exp);
      check("display1_1", d11, exp_disp(m_cnt / 10, (m_cnt / 10) == 0));
      check("display2_1", d21, exp_disp(m_cnt % 10, 1'b0));
    end
  end

  task automatic cyc(input bit r, input bit f, input bit s, input bit p);
    rst = r; reload_full = f; reload_short = s; pause = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit s9 = 0;
    bit s10 = 0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_th", th0, 2);
    check("rst_tl", tl0, 4);
    check("rst_alarm", al0, 0);
    check("rst_expired", ex0, 0);
    check("rst_d1", d10, 7'b0100100);
    check("rst_d2", d20, 7'b0011001);

    repeat (3) cyc(0, 0, 0, 0);
    check("pre_tick_tl", tl0, 4);
    cyc(0, 0, 0, 0);
    check("tick4_tl", tl0, 3);
    check("tick4_d2", d20, 7'b0110000);

    repeat (12) cyc(0, 0, 0, 0);
    check("at20_th", th0, 2);
    check("at20_tl", tl0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    check("wrap_th", th0, 1);
    check("wrap_tl", tl0, 9);

    repeat (2) cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 1);
    check("pause_hold", tl0, 9);
    cyc(0, 0, 0, 0);
    check("resume1", tl0, 9);
    cyc(0, 0, 0, 0);
    check("resume2", tl0, 8);

    for (int i = 0; i < 200 && m_cnt != 7; i++) begin
      cyc(0, 0, 0, 0);
      if (m_cnt == 10 && !s10) begin
        s10 = 1;
        check("blank_ten", d11, 7'b1111001);
      end
      if (m_cnt == 9 && !s9) begin
        s9 = 1;
        check("blank_nine", d11, 7'b1111111);
      end
    end
    check("at07_tl", tl0, 7);

    cyc(0, 0, 1, 0);
    check("short_th", th0, 1);
    check("short_tl", tl0, 4);
    cyc(0, 1, 1, 0);
    check("both_th", th0, 2);
    check("both_tl", tl0, 4);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    check("rst_short_th", th0, 2);
    check("rst_short_tl", tl0, 4);
    repeat (3) cyc(0, 0, 0, 0);
    check("presc_clr_hold", tl0, 4);
    cyc(0, 0, 0, 0);
    check("presc_clr_tick", tl0, 3);

    for (int i = 0; i < 200 && !m_exp; i++) cyc(0, 0, 0, 0);
    check("exp_flag", ex0, 1);
    check("exp_alarm", al0, 1);
    check("exp_tl", tl0, 0);
    check("exp_th", th0, 0);
    repeat (2) cyc(0, 0, 0, 1'($urandom_range(0, 1)));
    check("alarm_hold", al0, 1);
    cyc(0, 0, 0, 0);
    check("alarm_drop", al0, 0);
    check("exp_stays", ex0, 1);
    repeat (20) cyc(0, 0, 0, 1'($urandom_range(0, 1)));
    check("exp_stable_tl", tl0, 0);
    check("exp_stable_ex", ex0, 1);

    cyc(0, 0, 1, 0);
    for (int i = 0; i < 200 && !m_exp; i++) cyc(0, 0, 0, 0);
    check("exp2_alarm", al0, 1);
    cyc(0, 1, 0, 0);
    check("rl_alarm", al0, 0);
    check("rl_expired", ex0, 0);
    check("rl_th", th0, 2);
    check("rl_tl", tl0, 4);
    repeat (3) cyc(0, 0, 0, 0);
    check("rl_hold", tl0, 4);
    cyc(0, 0, 0, 0);
    check("rl_tick", tl0, 3);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
